// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side drain stage and the FIFO
// interface definitions.
package fifo_pkg;

    localparam int DATA_W     = 8;
    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // True when the words already committed (buffered plus in flight, minus the
    // word leaving this cycle) leave room for one more read to be issued.
    function automatic logic has_room(
        input occ_t occ,
        input logic inflight,
        input logic pop
    );
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return committed < 3'(SKID_DEPTH);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_rd_drain_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of the
// drain stage; master is the drain block, slave is the FIFO plus consumer.
interface fifo_rd_drain_if #(
    parameter int DATA_W = fifo_pkg::DATA_W
);

    // FIFO side: i_rddata is meaningful only the cycle after o_rden was high.
    logic              o_rden;
    logic [DATA_W-1:0] i_rddata;
    logic              i_empty;

    // Stream side: a word transfers on a posedge where m_valid && m_ready;
    // m_valid never depends on m_ready, and m_valid/m_data hold while stalled.
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        output o_rden,
        input  i_rddata,
        input  i_empty,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        input  o_rden,
        output i_rddata,
        input  m_valid,
        output i_empty,
        output m_ready,
        input  m_data
    );

endinterface : fifo_rd_drain_if

// File: rtl/fifo_drain_skid.sv
// Two-entry landing buffer of the drain stage: storage, wrapping 1-bit
// pointers and occupancy. Flush has priority over push and pop.
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int WORD_W = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_data_o,
    output occ_t              occ_o
);

    logic [SKID_DEPTH-1:0][WORD_W-1:0] mem_q, mem_d;
    logic                              wr_ptr_q, wr_ptr_d;
    logic                              rd_ptr_q, rd_ptr_d;
    occ_t                              occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + occ_t'(push_i) - occ_t'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign occ_o       = occ_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush_i)
        !(pop_i && (occ_q == 2'd0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush_i)
        !(push_i && !pop_i && (occ_q == occ_t'(SKID_DEPTH))));

endmodule : fifo_drain_skid

// File: rtl/fifo_rd_drain.sv
// Read-side drain stage: issues FIFO reads, absorbs the one-cycle read latency
// and presents words on a valid/ready stream. Optional FIFO_DRAIN_STATS_EN adds
// saturating stall/word counters.
module fifo_rd_drain #(
    parameter int DATA_W     = fifo_pkg::DATA_W,
    parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    fifo_rd_drain_if.master bus,
    output fifo_pkg::occ_t  o_occ
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]     o_stall_cnt,
    output logic [15:0]     o_word_cnt
`endif
);

    logic              inflight_q, inflight_d;
    logic              rden;
    logic              push;
    logic              pop;
    fifo_pkg::occ_t    occ;
    logic [DATA_W-1:0] head_data;

    assign pop  = bus.m_valid && bus.m_ready;
    assign push = inflight_q;

    // Issue only while the buffer can still take every word already promised.
    always_comb begin
        rden = 1'b0;
        if (!rst && !i_flush && !bus.i_empty) begin
            rden = fifo_pkg::has_room(occ, inflight_q, pop);
        end
        inflight_d = rden;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_drain_skid #(
        .WORD_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (i_flush),
        .push_i      (push),
        .push_data_i (bus.i_rddata),
        .pop_i       (pop),
        .head_data_o (head_data),
        .occ_o       (occ)
    );

    assign bus.o_rden  = rden;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head_data;
    assign o_occ       = occ;

    a_depth_fixed: assert property (@(posedge clk) SKID_DEPTH == 2);

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    // Counters survive i_flush; only reset clears them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        word_cnt_d  = word_cnt_q;
        if (bus.m_valid && !bus.m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (pop && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            word_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_word_cnt  = word_cnt_q;
`endif

endmodule : fifo_rd_drain

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage that sits directly downstream of the synchronous FIFO. It issues read enables into the FIFO, absorbs the FIFO's one-cycle read latency, and presents the words on a valid/ready stream port. The block never overflows its internal buffer and sustains one word per cycle when the consumer is always ready. Downstream consumers (packet parsers, scoreboard taps) therefore never need to handle the FIFO's raw read timing.

## Interface
Parameters:
- DATA_W, default from package (8): FIFO word width.
- SKID_DEPTH, fixed 2: internal buffer entries; any other value is unsupported.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous flush of buffered and in-flight data.
- o_rden  out  1  read enable to the FIFO; drives the FIFO's i_rden.
- i_rddata  in  DATA_W  FIFO read data, valid the cycle after o_rden.
- i_empty  in  1  FIFO empty flag.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_W  stream data, head of buffer.
- o_occ  out  2  buffer occupancy, 0..2.

## Operation
- State: `occ` (0..2), `inflight` (1 bit, registered o_rden), 1-bit write and read pointers into a 2-entry buffer.
- pop = m_valid && m_ready. push = inflight (data landing this edge).
- o_rden = !rst && !i_flush && !i_empty && ((occ + inflight - pop) < 2). Combinational from registered state, i_empty, m_ready.
- occ_next = occ + push - pop. An underflow or overflow is a design bug; add an assertion for it.
- m_valid = (occ != 0). m_data = buffer[rd_ptr]. Both are registered-state driven; no combinational path from i_rddata.
- Simultaneous push and pop at occ=1 or occ=2: both happen and occ is unchanged. Pointers advance independently and wrap modulo 2.
- i_flush: at the edge, occ, inflight and both pointers clear. A word landing that cycle is discarded. o_rden is 0 during flush. m_valid is 0 from the next cycle.
- The block does not use i_empty for data qualification. inflight alone marks valid i_rddata.

## Timing
- Reset values: o_rden=0, m_valid=0, m_data=0, o_occ=0, inflight=0, pointers=0.
- Reset mid-operation: an in-flight FIFO read is lost. The FIFO has already popped it. This is accepted and documented.
- Latency: o_rden high in cycle N, then i_rddata captured at the end of N+1, then m_valid high in N+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, o_rden stays high every cycle and m_valid stays high every cycle from N+2.
- Backpressure: with m_ready=0, at most 2 words are accepted (occ + inflight ≤ 2). o_rden deasserts in the same cycle the limit is reached.
- m_valid and m_data are held stable while m_valid && !m_ready.

## Configuration
- FIFO_DRAIN_STATS_EN defined: adds o_stall_cnt (16 bit), which counts cycles with m_valid && !m_ready, and o_word_cnt (16 bit), which counts pops. Both saturate at 0xFFFF, clear on rst, and do not clear on i_flush.
- Undefined: both ports and counters are absent. Core behaviour is identical.

## Structure
- Package fifo_pkg: DATA_W constant, SKID_DEPTH constant, occ_t typedef (logic [1:0]), shared with the FIFO interface definitions.
- Sub-module fifo_drain_skid: 2-entry storage, pointers and occ. It exposes push/pop/data/occ. The parent holds the issue logic, the inflight register and the stats.

## Test plan
- Reset, then preload FIFO with 0x11,0x22,0x33 and hold m_ready=1. Expect o_rden in 3 consecutive cycles, m_valid 2 cycles after the first o_rden, and m_data 0x11,0x22,0x33 back-to-back, then m_valid=0.
- Preload 5 words and hold m_ready=0. Expect exactly 2 o_rden pulses, o_occ=2, and m_data stable at word0. Raise m_ready: all 5 words arrive in order with no gaps after the first.
- Alternate m_ready 1/0 every cycle with 8 words. Expect in-order delivery 0..7 and o_occ never above 2.
- Hold i_empty=1 with m_ready=1. Expect o_rden=0 and m_valid=0 indefinitely.
- Assert i_flush in the cycle after an o_rden with occ=1. Expect the landing word discarded, o_occ=0 and m_valid=0 next cycle, and subsequent reads resuming correctly.
- With FIFO_DRAIN_STATS_EN: stall 10 cycles, then pop 4 words. Expect o_stall_cnt=10 and o_word_cnt=4. Force 70000 stall cycles and expect saturation at 0xFFFF.
